// File: rtl/pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control logic:
// controller FSM encoding and control-field bit positions of the pipeline buffers.
package pipe_pkg;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  // M field of ID/EX and EX/MEM
  localparam int M_BRANCH = 2;
  localparam int M_MEMRD  = 1;
  localparam int M_MEMWR  = 0;

  // WB field of ID/EX, EX/MEM and MEM/WB
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

endpackage

// File: rtl/hazard_ld_use.sv
// Load-use comparator: the load in ID/EX writes a register that the
// instruction in IF/ID reads. Register 0 is never a real dependency.
module hazard_ld_use (
  input  logic       idex_memread_i,
  input  logic [4:0] idex_rt_i,
  input  logic [4:0] ifid_rs_i,
  input  logic [4:0] ifid_rt_i,
  output logic       hazard_o
);

  assign hazard_o = idex_memread_i && (idex_rt_i != 5'd0) &&
                    ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline controller: freezes on data-memory wait states, flushes on
// branches taken in MEM, stalls on load-use, with a wait watchdog and stall counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rt,
  input  logic [2:0]       exmem_m,
  input  logic             exmem_zf,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_write,
  output logic             exmem_flush,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output state_e           state_dbg
);

  localparam int WC_RAW = $clog2(MAX_WAIT + 1);
  localparam int WC_W   = (WC_RAW < 4) ? 4 : WC_RAW;
  localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(MAX_WAIT);

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             mem_timeout_q, mem_timeout_d;

  logic mem_acc, freeze, branch_taken, ld_use_hz, load_use;

  // mem_ready qualifies the EX/MEM access: a pending access completes in the
  // cycle mem_ready is high; until then the whole pipeline holds.
  assign mem_acc      = exmem_m[M_MEMRD] | exmem_m[M_MEMWR];
  assign freeze       = mem_acc & ~mem_ready;
  assign branch_taken = exmem_m[M_BRANCH] & exmem_zf & ~freeze;
  assign load_use     = ld_use_hz & ~freeze & ~branch_taken;

  hazard_ld_use u_ld_use (
    .idex_memread_i (idex_memread),
    .idex_rt_i      (idex_rt),
    .ifid_rs_i      (ifid_rs),
    .ifid_rt_i      (ifid_rt),
    .hazard_o       (ld_use_hz)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        wait_cnt_d = '0;
        if (freeze) begin
          state_d    = ST_WAIT;
          wait_cnt_d = WC_W'(1);
        end
      end
      ST_WAIT: begin
        if (mem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_MAX) begin
          state_d = ST_ERR;
        end else if (freeze) begin
          wait_cnt_d = wait_cnt_q + WC_W'(1);
        end
      end
      ST_ERR: begin
        if (mem_ready) begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase

    mem_timeout_d = mem_timeout_q | (state_d == ST_ERR);

    stall_cnt_d = stall_cnt_q;
    if ((freeze || load_use) && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_comb begin
    pc_write     = 1'b1;
    pc_src       = 1'b0;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    exmem_flush  = 1'b0;
    memwb_bubble = 1'b0;
    if (rst) begin
      // fill every buffer with NOPs while reset is held
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_flush  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (freeze) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      exmem_write  = 1'b0;
      memwb_bubble = 1'b1;
    end else if (branch_taken) begin
      pc_src      = 1'b1;
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      exmem_flush = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign state_dbg   = state_q;

endmodule
